// File: rtl/doc_uart_tx.sv
// Streams the document RAM out over a UART 8N1 line, row by row, with CR LF after every row.
// Owns the RAM read port from the first FETCH through FIN, then pulses done.
module doc_uart_tx #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115200,
  parameter int ROWS   = 15,
  parameter int COLS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       read_enable,
  output logic [9:0] read_addr,
  input  logic [7:0] read_data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int          DIV      = CLK_HZ / BAUD;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
  localparam logic [4:0]  COL_LAST = 5'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_NEXT,
    S_EOL,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [1:0]  eol_q, eol_d;
  logic [7:0]  byte_q, byte_d;
  logic [9:0]  shift_q, shift_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      eol_q   <= '0;
      byte_q  <= '0;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      eol_q   <= eol_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // eol_q: 0 = sending cells, 1 = CR queued/sent, 2 = LF queued/sent
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    eol_d   = eol_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        byte_d  = (read_data == 8'h00) ? 8'h20 : read_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = {1'b1, byte_q, 1'b0};
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (baud_q == DIV_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_NEXT;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_NEXT: begin
        if (eol_q == 2'd0 && col_q < COL_LAST) begin
          col_d   = col_q + 5'd1;
          state_d = S_FETCH;
        end else if (eol_q != 2'd2) begin
          eol_d   = eol_q + 2'd1;
          state_d = S_EOL;
        end else begin
          eol_d = 2'd0;
          if (row_q < ROW_LAST) begin
            row_d   = row_q + 4'd1;
            col_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_EOL: begin
        byte_d  = (eol_q == 2'd1) ? 8'h0D : 8'h0A;
        state_d = S_LOAD;
      end
      S_FIN: begin
        row_d   = '0;
        col_d   = '0;
        eol_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from reset flops so an async reset clears them at once.
  assign busy        = (state_q != S_IDLE);
  assign read_enable = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign read_addr   = {1'b0, row_q, col_q};
  assign tx          = (state_q == S_SHIFT) ? shift_q[0] : 1'b1;

endmodule
